// File: rtl/pipelined_bk_adder.sv
// Pipelined adder: group-ripple carries inside each group, Brent-Kung prefix tree across groups.
// Optional macro BK_ADDER_SUB_EN turns sub=1 into a - b (b inverted, carry-in forced to 1).
module pipelined_bk_adder #(
  parameter int WIDTH     = 32,
  parameter int GROUPSIZE = 4,
  parameter int STAGES    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c0,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   s,
  output logic             ovf
);

  localparam int NG     = WIDTH / GROUPSIZE;
  localparam int LOG_NG = $clog2(NG);
  // Payload between boundaries: {a, b', c', group generate, group propagate}.
  localparam int PW     = 2 * WIDTH + 1 + 2 * NG;

  // b' and c' are resolved up front, so the subtract request rides along inside the beat.
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
`ifdef BK_ADDER_SUB_EN
  assign b_eff = sub ? ~b : b;
  assign c_eff = sub | c0;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_eff      = b;
  assign c_eff      = c0;
`endif

  // ---------------- handshake: per-stage valid bits ----------------
  logic [STAGES-1:0] v_reg;
  logic [STAGES:0]   load_ext;
  logic [STAGES:0]   v_chain;

  assign v_chain = {v_reg, in_valid};

  // load_ext[k]: stage k may capture this cycle; load_ext[STAGES] is the downstream sink.
  always_comb begin
    load_ext         = '0;
    load_ext[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      load_ext[k] = ~v_reg[k] | load_ext[k+1];
    end
  end

  assign in_ready  = rst_n & load_ext[0];
  assign out_valid = v_reg[STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_reg <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load_ext[k]) v_reg[k] <= v_chain[k];
      end
    end
  end

  // ---------------- step 1: per-group generate/propagate by ripple ----------------
  logic [WIDTH-1:0] bit_g, bit_p;
  logic [NG-1:0]    grp_g, grp_p;

  assign bit_g = a & b_eff;
  assign bit_p = a ^ b_eff;

  always_comb begin
    grp_g = '0;
    grp_p = '0;
    for (int i = 0; i < NG; i++) begin
      grp_p[i] = 1'b1;
      for (int j = 0; j < GROUPSIZE; j++) begin
        grp_g[i] = bit_g[i*GROUPSIZE+j] | (bit_p[i*GROUPSIZE+j] & grp_g[i]);
        grp_p[i] = grp_p[i] & bit_p[i*GROUPSIZE+j];
      end
    end
  end

  logic [PW-1:0] f1_out, x1;
  assign f1_out = {a, b_eff, c_eff, grp_g, grp_p};

  if (STAGES == 3) begin : g_reg1
    logic [PW-1:0] r1_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                      r1_reg <= '0;
      else if (load_ext[0] && in_valid) r1_reg <= f1_out;
    end
    assign x1 = r1_reg;
  end else begin : g_comb1
    assign x1 = f1_out;
  end

  // ---------------- step 2: Brent-Kung up-sweep ----------------
  logic [NG-1:0] up_g, up_p;

  // In place: at level l node i reads node i-2^l, which this level never rewrites.
  always_comb begin
    up_g = x1[2*NG-1:NG];
    up_p = x1[NG-1:0];
    for (int l = 0; l < LOG_NG; l++) begin
      for (int i = 0; i < NG; i++) begin
        if (((i + 1) % (2 << l)) == 0) begin
          up_g[i] = up_g[i] | (up_p[i] & up_g[i-(1<<l)]);
          up_p[i] = up_p[i] & up_p[i-(1<<l)];
        end
      end
    end
  end

  logic [PW-1:0] f2_out, x2;
  assign f2_out = {x1[PW-1:2*NG], up_g, up_p};

  if (STAGES >= 2) begin : g_reg2
    localparam int K2 = STAGES - 2;
    logic [PW-1:0] r2_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                           r2_reg <= '0;
      else if (load_ext[K2] && v_chain[K2]) r2_reg <= f2_out;
    end
    assign x2 = r2_reg;
  end else begin : g_comb2
    assign x2 = f2_out;
  end

  // ---------------- step 3: down-sweep, group carries, sum ----------------
  logic [WIDTH-1:0] x2_a, x2_bp, x2_gb, x2_pb;
  logic             x2_cin;
  logic [NG-1:0]    pre_g, pre_p;
  logic [WIDTH:0]   sum_c;
  logic             grp_c, rc, ovf_c;

  assign x2_a   = x2[2*NG+1+WIDTH +: WIDTH];
  assign x2_bp  = x2[2*NG+1 +: WIDTH];
  assign x2_cin = x2[2*NG];
  assign x2_gb  = x2_a & x2_bp;
  assign x2_pb  = x2_a ^ x2_bp;

  always_comb begin
    pre_g = x2[2*NG-1:NG];
    pre_p = x2[NG-1:0];
    for (int l = LOG_NG - 1; l >= 0; l--) begin
      for (int i = 0; i < NG; i++) begin
        if (i >= (2 << l) && ((i + 1) % (2 << l)) == (1 << l)) begin
          pre_g[i] = pre_g[i] | (pre_p[i] & pre_g[i-(1<<l)]);
          pre_p[i] = pre_p[i] & pre_p[i-(1<<l)];
        end
      end
    end
    // Ripple only inside a group; the carry into the next group comes from the prefix tree.
    sum_c = '0;
    grp_c = x2_cin;
    rc    = 1'b0;
    for (int i = 0; i < NG; i++) begin
      rc = grp_c;
      for (int j = 0; j < GROUPSIZE; j++) begin
        sum_c[i*GROUPSIZE+j] = x2_pb[i*GROUPSIZE+j] ^ rc;
        rc = x2_gb[i*GROUPSIZE+j] | (x2_pb[i*GROUPSIZE+j] & rc);
      end
      grp_c = pre_g[i] | (pre_p[i] & x2_cin);
    end
    sum_c[WIDTH] = grp_c;
  end

  assign ovf_c = (x2_a[WIDTH-1] == x2_bp[WIDTH-1]) & (sum_c[WIDTH-1] != x2_a[WIDTH-1]);

  localparam int KO = STAGES - 1;
  logic [WIDTH:0] s_reg;
  logic           ovf_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_reg   <= '0;
      ovf_reg <= 1'b0;
    end else if (load_ext[KO] && v_chain[KO]) begin
      s_reg   <= sum_c;
      ovf_reg <= ovf_c;
    end
  end

  assign s   = s_reg;
  assign ovf = ovf_reg;

endmodule

// File: doc/pipelined_bk_adder.md
PIPELINED_BK_ADDER -- requirements
Module: pipelined_bk_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width; legal values 8..128, multiple of GROUPSIZE.
REQ-002 SHALL have parameter GROUPSIZE, default 4, bits per carry group; power of two; WIDTH/GROUPSIZE SHALL be a power of two.
REQ-003 SHALL have parameter STAGES, default 3, pipeline depth; legal values 1, 2, 3.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 Port list, in order:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat offered
- in_ready  output  1  block accepts the beat this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- c0  input  1  carry-in
- sub  input  1  subtract request (see Configuration)
- out_valid  output  1  result beat offered
- out_ready  input  1  downstream accepts the result beat
- s  output  WIDTH+1  sum; bit WIDTH is the carry-out
- ovf  output  1  signed two's-complement overflow

Function
REQ-006 SHALL compute s = a + b' + c' with full WIDTH+1 result; b' = b, c' = c0 unless subtracting.
REQ-007 Carry network SHALL be group-ripple inside each GROUPSIZE group plus a Brent-Kung prefix tree (up-sweep, then down-sweep) across the WIDTH/GROUPSIZE group generate/propagate pairs.
REQ-008 Register boundaries:
- STAGES=3: after group g/p, after up-sweep, at output.
- STAGES=2: after up-sweep, at output.
- STAGES=1: output only.
REQ-009 Latency SHALL be exactly STAGES cycles from accepted input beat to out_valid, with no stalls.
REQ-010 Each stage SHALL hold a valid bit; stage k loads when it is empty or its contents move to stage k+1 in the same cycle; the last stage moves when out_ready=1.
REQ-011 in_ready SHALL equal (stage 0 empty) OR (stage 0 moves this cycle); a beat transfers only when in_valid and in_ready are both 1.
REQ-012 Full throughput: one beat per cycle SHALL be sustained while out_ready=1.
REQ-013 While out_valid=1 and out_ready=0, s, ovf and out_valid SHALL hold stable; no beat SHALL be dropped or duplicated.
REQ-014 Beats SHALL emerge in acceptance order.
REQ-015 Simultaneous accept at the input and drain at the output in a full pipeline SHALL advance every stage by one and lose no data.
REQ-016 ovf SHALL be 1 iff a[WIDTH-1] == b'[WIDTH-1] and s[WIDTH-1] != a[WIDTH-1].
REQ-017 Wrap-around: all-ones + 1 SHALL yield s[WIDTH-1:0]=0, s[WIDTH]=1.

Reset
REQ-018 Asserting rst_n=0 SHALL immediately clear all stage valid bits; out_valid=0, s=0, ovf=0.
REQ-019 in_ready SHALL be 0 while rst_n=0 and 1 in the first cycle after release.
REQ-020 Reset mid-operation SHALL discard all in-flight beats; none SHALL appear after release.

Configuration
REQ-021 Macro BK_ADDER_SUB_EN: when defined and sub=1, b' = ~b and c' = 1 (c0 ignored), giving a - b; the sub bit travels with its beat through the pipeline.
REQ-022 Without BK_ADDER_SUB_EN, the sub input SHALL be ignored (treated as 0) and no inversion logic is synthesised.

Verification
REQ-023 WIDTH=32, STAGES=3, out_ready=1: a=0xFFFFFFFF, b=0x1, c0=0 -> 3 cycles later out_valid=1, s=0x1_00000000, ovf=0.
REQ-024 a=0x7FFFFFFF, b=0x1, c0=0 -> s=0x0_80000000, ovf=1.
REQ-025 BK_ADDER_SUB_EN defined: a=5, b=7, sub=1 -> s[31:0]=0xFFFFFFFE, s[32]=0, ovf=0; without macro the same stimulus -> s=12.
REQ-026 Stream 8 back-to-back beats a=i, b=i (i=0..7), out_ready low on cycles 4-6 -> in_ready drops once the 3 stages are full; outputs 0,2,...,14 in order, none lost or duplicated; held output stable while stalled.
REQ-027 Assert rst_n=0 with 2 beats in flight -> out_valid=0 at once; after release, no stale beat; next beat a=1, b=2, c0=1 -> s=4.
REQ-028 Random a/b/c0/sub for WIDTH in {16,32,64}, GROUPSIZE in {2,4}, STAGES in {1,2,3}, random out_ready -> all results match the reference model, with latency exactly STAGES cycles when unstalled.
